mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 4: SRAM access cycles per transaction; legal range 1..15.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 if_req  in  1  instruction-fetch read request from fetch stage.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  fetched instruction word.
REQ-007 if_ready  out  1  one-cycle pulse: fetch transaction complete, if_rdata valid.
REQ-008 mem_rd_en  in  1  data-load request from memory stage.
REQ-009 mem_wr_en  in  1  data-store request from memory stage.
REQ-010 mem_addr  in  32  data byte address.
REQ-011 mem_wdata  in  32  store data.
REQ-012 mem_rdata  out  32  load data.
REQ-013 mem_ready  out  1  one-cycle pulse: data transaction complete, mem_rdata valid for loads.
REQ-014 freeze_if  out  1  stall fetch stage (PC and fetch pipeline register hold).
REQ-015 freeze_mem  out  1  stall memory stage and all older-stage registers.
REQ-016 sram_addr  out  16  SRAM word address.
REQ-017 sram_wdata  out  32  SRAM write data.
REQ-018 sram_rdata  in  32  SRAM read data, valid during last access cycle.
REQ-019 sram_en  out  1  SRAM access enable.
REQ-020 sram_we  out  1  SRAM write enable, active-high, qualified by sram_en.

Function
REQ-021 States: IDLE, ACCESS, DONE; one-hot or binary encoding permitted.
REQ-022 IDLE: mem_rd_en|mem_wr_en present -> latch data request, owner=MEM, go ACCESS; else if_req -> latch fetch, owner=IF, go ACCESS; else stay IDLE.
REQ-023 Fixed priority: data port always wins over fetch when both pending in IDLE.
REQ-024 mem_rd_en and mem_wr_en both high -> treated as write.
REQ-025 Grant latches address bits [17:2] into sram_addr, mem_wdata into sram_wdata, write flag into sram_we; bits [1:0] ignored; bits [31:18] ignored.
REQ-026 ACCESS: sram_en=1, held exactly WAIT_CYCLES cycles via down-counter loaded with WAIT_CYCLES-1 at grant; latched address/data/we stable throughout.
REQ-027 Last ACCESS cycle (counter=0): reads capture sram_rdata into shared read register; go DONE.
REQ-028 DONE: sram_en=0; pulse if_ready or mem_ready (owner only) for exactly one cycle; go IDLE unconditionally.
REQ-029 if_rdata and mem_rdata both driven from shared read register; value held until next read capture; writes do not alter it.
REQ-030 Latency: request sampled in IDLE cycle N -> ready asserted in cycle N+WAIT_CYCLES+1; minimum spacing between grants WAIT_CYCLES+2 cycles.
REQ-031 freeze_mem = (mem_rd_en|mem_wr_en) & ~mem_ready, combinational.
REQ-032 freeze_if = (if_req & ~if_ready) | freeze_mem, combinational.
REQ-033 Requesters hold request and operands stable until their ready pulse; input changes after grant have no effect on the transaction in progress.
REQ-034 Request dropped mid-transaction: transaction completes, ready still pulses, SRAM write (if any) still performed.
REQ-035 Pending fetch while data access active: fetch waits; granted in first IDLE cycle with no data request.
REQ-036 No request in IDLE: sram_en=0, sram_we=0, no ready pulses.

Reset
REQ-037 rst=0 forces immediately, regardless of state or clock: state IDLE, counter 0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, read register=0, if_ready=0, mem_ready=0.
REQ-038 Reset asserted mid-ACCESS aborts transaction; no ready pulse emitted afterward; rdata outputs read 0.
REQ-039 After rst deasserts, first grant no earlier than first rising edge with rst=1.

Verification
REQ-040 Fetch only: if_req=1, if_addr=0x0000_0010, sram_rdata=0x0401_1000 -> sram_addr=0x0004, sram_en 4 cycles, if_ready pulse cycle N+5, if_rdata=0x0401_1000, freeze_if high cycles N..N+4.
REQ-041 Simultaneous: if_req=1 and mem_rd_en=1 (mem_addr=0x400) same cycle -> data served first (sram_addr=0x0100), mem_ready at N+5, fetch granted N+6, if_ready at N+11; freeze_if high throughout.
REQ-042 Store: mem_wr_en=1, mem_addr=0x404, mem_wdata=0xDEAD_BEEF -> sram_we=1, sram_addr=0x0101, sram_wdata=0xDEAD_BEEF for 4 cycles; mem_ready pulse; mem_rdata unchanged.
REQ-043 Both enables: mem_rd_en=mem_wr_en=1 -> sram_we=1 (write performed), no read capture.
REQ-044 Reset mid-op: assert rst=0 during 2nd ACCESS cycle of a load -> all outputs 0 asynchronously, no mem_ready after release; new load after release completes normally.
REQ-045 WAIT_CYCLES=1: back-to-back fetches -> ready every 3 cycles; drop if_req during ACCESS -> if_ready still pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between the instruction-fetch port
// and the data (load/store) port. Data requests have fixed priority over fetch.
// Each transaction is IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (ready pulse).
module mem_arbiter #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        freeze_if,
  output logic        freeze_mem,
  output logic [15:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_en,
  output logic        sram_we
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        owner_mem;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        mem_any;
  logic        grant;
  logic        unused_addr_bits;

  assign mem_any = mem_rd_en | mem_wr_en;
  assign grant   = (state == IDLE) & (mem_any | if_req);

  // Only word-address bits [17:2] reach the SRAM.
  assign unused_addr_bits = ^{if_addr[31:18], if_addr[1:0], mem_addr[31:18], mem_addr[1:0]};

  // Both read ports share one capture register.
  assign if_rdata  = rdata_q;
  assign mem_rdata = rdata_q;

  // Stall requesters until their own ready pulse.
  assign freeze_mem = mem_any & ~mem_ready;
  assign freeze_if  = (if_req & ~if_ready) | freeze_mem;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and per-state SRAM/handshake outputs.
  always_comb begin
    state_nx  = state;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    case (state)
      IDLE: begin
        if (mem_any || if_req) state_nx = ACCESS;
      end
      ACCESS: begin
        sram_en = 1'b1;
        sram_we = we_q;
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        if_ready  = ~owner_mem;
        mem_ready = owner_mem;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant latching, access down-counter and read capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      owner_mem  <= 1'b0;
      we_q       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rdata_q    <= '0;
    end else if (grant) begin
      cnt        <= CNT_LOAD;
      owner_mem  <= mem_any;
      we_q       <= mem_wr_en;
      sram_addr  <= mem_any ? mem_addr[17:2] : if_addr[17:2];
      sram_wdata <= mem_wdata;
    end else if (state == ACCESS) begin
      if (cnt == 4'd0) begin
        if (!we_q) rdata_q <= sram_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule
